// File: rtl/alu_core.sv
// alu_core: multi-cycle ALU with operand-B select and a registered single-pulse result.
// Define ALU_MULT_EN to build the iterative shift-add multiplier; otherwise OP=2 returns 0.
module alu_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_act,
    input  logic [3:0]            i_op,
    input  logic [1:0]            i_movi,
    input  logic [DATA_WIDTH-1:0] i_reg_a,
    input  logic [DATA_WIDTH-1:0] i_reg_b,
    input  logic [DATA_WIDTH-1:0] i_mem,
    input  logic [DATA_WIDTH-1:0] i_imm,
    output logic                  o_alu_rdy,
    output logic [DATA_WIDTH-1:0] o_ex_alu,
    output logic                  o_ex_alu_vld
);
    typedef enum logic [1:0] {IDLE, EXEC, MULT, DONE} state_t;
    localparam logic [DATA_WIDTH-1:0] ONE = 1;
    state_t                r_state;
    logic [3:0]            r_op;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_ex_alu;
    logic                  r_rdy;
    logic                  r_vld;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_accept;
`ifdef ALU_MULT_EN
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] w_acc_next;
    assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
`endif
    assign o_alu_rdy    = r_rdy;
    assign o_ex_alu     = r_ex_alu;
    assign o_ex_alu_vld = r_vld;
    assign w_b      = i_movi == 2'b01 ? i_mem : i_movi == 2'b10 ? i_imm : i_reg_b;
    assign w_accept = r_state == IDLE && r_rdy && i_act;
    always_comb begin
        w_res = '0;
        case (r_op)
            4'd0:  w_res = r_a + r_b;
            4'd1:  w_res = r_a - r_b;
            4'd2:  w_res = '0;
            4'd3:  w_res = r_a << 1;
            4'd4:  w_res = r_a >> 1;
            4'd5:  w_res = {r_a[DATA_WIDTH-2:0], r_a[DATA_WIDTH-1]};
            4'd6:  w_res = {r_a[0], r_a[DATA_WIDTH-1:1]};
            4'd7:  w_res = ~r_a;
            4'd8:  w_res = r_a & r_b;
            4'd9:  w_res = r_a | r_b;
            4'd10: w_res = r_a ^ r_b;
            4'd11: w_res = ~(r_a & r_b);
            4'd12: w_res = ~(r_a | r_b);
            4'd13: w_res = ~(r_a ^ r_b);
            4'd14: w_res = r_a + ONE;
            4'd15: w_res = r_a - ONE;
        endcase
    end
    // Ready lags the return to IDLE by one cycle, giving one acceptance per four cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ex_alu <= '0;
            r_rdy    <= 1'b1;
            r_vld    <= 1'b0;
`ifdef ALU_MULT_EN
            r_acc    <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            r_rdy <= r_state == IDLE && !w_accept;
            r_vld <= r_state == DONE;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op <= i_op;
                    r_a  <= i_reg_a;
                    r_b  <= w_b;
`ifdef ALU_MULT_EN
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= i_op == 4'd2 ? MULT : EXEC;
`else
                    r_state <= EXEC;
`endif
                end
                EXEC: begin
                    r_ex_alu <= w_res;
                    r_state  <= DONE;
                end
`ifdef ALU_MULT_EN
                MULT: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(DATA_WIDTH - 1)) begin
                        r_ex_alu <= w_acc_next;
                        r_state  <= DONE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed checks of alu_core at DATA_WIDTH=8 (both ALU_MULT_EN builds).
module tb_alu_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       act = 1'b0;
    logic [3:0] op = '0;
    logic [1:0] movi = '0;
    logic [7:0] reg_a = '0, reg_b = '0, mem = '0, imm = '0;
    logic       rdy, vld;
    logic [7:0] ex_alu;
    int checks = 0;
    int errors = 0;

    alu_core #(.DATA_WIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_act(act), .i_op(op), .i_movi(movi),
        .i_reg_a(reg_a), .i_reg_b(reg_b), .i_mem(mem), .i_imm(imm),
        .o_alu_rdy(rdy), .o_ex_alu(ex_alu), .o_ex_alu_vld(vld)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic scramble;
        op    = 4'($urandom);
        movi  = 2'($urandom);
        reg_a = 8'($urandom);
        reg_b = 8'($urandom);
        mem   = 8'($urandom);
        imm   = 8'($urandom);
    endtask

    // Single non-MULT-latency request: accepted at edge k, pulse at k+2, ready back at k+3.
    task automatic run(input string tag, input logic [3:0] o, input logic [1:0] m,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] me,
                       input logic [7:0] im, input logic [7:0] exp);
        op = o; movi = m; reg_a = a; reg_b = b; mem = me; imm = im; act = 1'b1;
        tick;
        act = 1'b0;
        scramble;
        chk1({tag, "/rdy_k"}, rdy, 1'b0);
        chk1({tag, "/vld_k"}, vld, 1'b0);
        tick;
        chk1({tag, "/rdy_k1"}, rdy, 1'b0);
        chk1({tag, "/vld_k1"}, vld, 1'b0);
        tick;
        chk1({tag, "/rdy_k2"}, rdy, 1'b0);
        chk1({tag, "/vld_k2"}, vld, 1'b1);
        chk8({tag, "/res"}, ex_alu, exp);
        tick;
        chk1({tag, "/rdy_k3"}, rdy, 1'b1);
        chk1({tag, "/vld_k3"}, vld, 1'b0);
        chk8({tag, "/hold"}, ex_alu, exp);
    endtask

`ifdef ALU_MULT_EN
    task automatic run_mult(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp);
        op = 4'd2; movi = 2'b00; reg_a = a; reg_b = b; act = 1'b1;
        tick;
        act = 1'b0;
        scramble;
        for (int i = 1; i <= 8; i++) begin
            tick;
            chk1({tag, "/vld_early"}, vld, 1'b0);
            chk1({tag, "/rdy_busy"}, rdy, 1'b0);
        end
        tick;
        chk1({tag, "/vld_k9"}, vld, 1'b1);
        chk8({tag, "/res"}, ex_alu, exp);
        tick;
        chk1({tag, "/vld_k10"}, vld, 1'b0);
        chk1({tag, "/rdy_k10"}, rdy, 1'b1);
    endtask
`endif

    initial begin
        tick;
        tick;
        chk1("rst/rdy", rdy, 1'b1);
        chk1("rst/vld", vld, 1'b0);
        chk8("rst/ex_alu", ex_alu, 8'h00);
        rst = 1'b0;

        run("add_wrap", 4'd0, 2'b00, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00);
        run("sub_imm",  4'd1, 2'b10, 8'h03, 8'h00, 8'h00, 8'h05, 8'hFE);
        run("sub_mem",  4'd1, 2'b01, 8'h03, 8'h00, 8'h01, 8'h05, 8'h02);
        run("and_m11",  4'd8, 2'b11, 8'hF0, 8'h3C, 8'hFF, 8'hFF, 8'h30);
        run("or",       4'd9, 2'b00, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'hFF);
        run("xor",      4'd10, 2'b00, 8'hA5, 8'h0F, 8'h00, 8'h00, 8'hAA);
        run("nand",     4'd11, 2'b00, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'hF0);
        run("nor",      4'd12, 2'b00, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00);
        run("xnor",     4'd13, 2'b00, 8'hA5, 8'h0F, 8'h00, 8'h00, 8'h55);
        run("not",      4'd7, 2'b00, 8'h5A, 8'hFF, 8'h00, 8'h00, 8'hA5);
        run("shl",      4'd3, 2'b00, 8'h81, 8'hFF, 8'h00, 8'h00, 8'h02);
        run("shr",      4'd4, 2'b00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00);
        run("rol",      4'd5, 2'b00, 8'h81, 8'hFF, 8'h00, 8'h00, 8'h03);
        run("ror",      4'd6, 2'b00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h80);
        run("inc",      4'd14, 2'b00, 8'hFF, 8'h55, 8'h00, 8'h00, 8'h00);
        run("dec",      4'd15, 2'b00, 8'h00, 8'h55, 8'h00, 8'h00, 8'hFF);
`ifdef ALU_MULT_EN
        run_mult("mult", 8'h0F, 8'h11, 8'hFF);
        run_mult("mult_trunc", 8'h10, 8'h11, 8'h10);
`else
        run("mult_off", 4'd2, 2'b00, 8'h0F, 8'h11, 8'h00, 8'h00, 8'h00);
`endif

        // ACT held high: accepts at samples 1, 5, 9; pulses at 3, 7, 11.
        op = 4'd5; movi = 2'b00; reg_a = 8'h81; reg_b = 8'h00; act = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick;
            chk1("held/vld", vld, (i % 4) == 3);
            chk1("held/rdy", rdy, (i % 4) == 0);
            if ((i % 4) == 3) chk8("held/res", ex_alu, 8'h03);
        end
        act = 1'b0;

        // Abort an in-flight operation with reset.
`ifdef ALU_MULT_EN
        op = 4'd2; movi = 2'b00; reg_a = 8'h0F; reg_b = 8'h11; act = 1'b1;
        tick;
        act = 1'b0;
        repeat (4) tick;
`else
        op = 4'd14; movi = 2'b00; reg_a = 8'h10; act = 1'b1;
        tick;
        act = 1'b0;
        tick;
        chk8("abort/pre", ex_alu, 8'h11);
`endif
        #1 rst = 1'b1;
        #1;
        chk1("abort/rdy", rdy, 1'b1);
        chk1("abort/vld", vld, 1'b0);
        chk8("abort/ex_alu", ex_alu, 8'h00);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            chk1("abort/no_pulse", vld, 1'b0);
        end
        chk8("abort/ex_idle", ex_alu, 8'h00);
        chk1("abort/rdy_idle", rdy, 1'b1);
        run("inc_after_rst", 4'd14, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
